avalon_mem_arbiter: RTL and testbench
=====================================

# avalon_mem_arbiter

Two-master arbiter sharing the single Avalon memory-mapped RAM slave between the CPU bus master (master 0) and the instruction/data loader master (master 1). Sits between `top_level_CPU`/loader and `RAM`, replacing the direct point-to-point bus hookup. Grants whole transfers with round-robin fairness and supports a bounded bus lock so the loader can write a program image without interleaved CPU accesses.

## Interface
- `LOCK_MAX`, 16: maximum consecutive locked transfers granted to master 1 before a forced release (1..255).
- `clk` input 1: system clock; all state updates on rising edge.
- `reset` input 1: synchronous, active-low reset.
- `m0_address` input 32, `m0_read` input 1, `m0_write` input 1, `m0_writedata` input 32, `m0_byteenable` input 4: CPU master request.
- `m0_waitrequest` output 1, `m0_readdata` output 32: CPU master response.
- `m1_address` input 32, `m1_read` input 1, `m1_write` input 1, `m1_writedata` input 32, `m1_byteenable` input 4: loader master request.
- `m1_lock` input 1: loader requests to keep the bus after its current transfer.
- `m1_waitrequest` output 1, `m1_readdata` output 32: loader master response.
- `s_address` output 32, `s_read` output 1, `s_write` output 1, `s_writedata` output 32, `s_byteenable` output 4: to RAM slave.
- `s_waitrequest` input 1, `s_readdata` input 32: from RAM slave.
- `grant` output 2: one-hot current owner (bit0 = master 0, bit1 = master 1); 00 when idle.

## Operation
- Request from master n: `mn_read | mn_write`. Simultaneous read and write from one master is illegal; arbiter forwards both unchanged.
- States: IDLE, GRANT0, GRANT1. Registers: state, `last` (last granted master, 1 bit), `lock_cnt` (8 bits).
- IDLE: no request -> IDLE. Only one requesting -> GRANTn. Both requesting -> grant the master not equal to `last`.
- GRANTn: slave outputs driven combinationally from master n; `mn_waitrequest = s_waitrequest`; `mn_readdata = s_readdata`. Other master: waitrequest = 1, readdata = 0.
- IDLE: `s_read = s_write = 0`, `s_address`/`s_writedata` = 0, `s_byteenable` = 0; both master waitrequests = 1, readdata = 0.
- Completion: in GRANTn, cycle with request asserted and `s_waitrequest = 0`. On completion: `last <= n`.
- GRANT0 completion -> IDLE.
- GRANT1 completion with `m1_lock = 1` and `lock_cnt + 1 < LOCK_MAX` -> stay GRANT1, `lock_cnt <= lock_cnt + 1`. Otherwise -> IDLE, `lock_cnt <= 0`.
- GRANTn with request dropped before completion (protocol violation): -> IDLE next cycle, no transfer counted, `lock_cnt <= 0`.
- Lock is sampled only at completion. `m1_lock` in IDLE has no effect on arbitration.

## Timing
- Reset (`reset = 0` at rising edge): state = IDLE, `last = 1` (master 0 wins first tie), `lock_cnt = 0`. From the next cycle: `grant = 00`, `s_read = s_write = 0`, both `mn_waitrequest = 1`, all readdata/slave data outputs 0.
- Reset mid-transfer aborts it. Slave strobes fall in the cycle after the reset edge. Master sees waitrequest = 1 and must re-issue.
- Grant latency: request first seen in IDLE at edge N -> GRANTn from edge N+1. Slave sees the transfer in cycle N+1.
- Zero-wait slave: unlocked transfer takes 2 cycles (IDLE + GRANT). Back-to-back requests from one master therefore issue every 2 cycles.
- Locked loader stream: one transfer per cycle after the first, at most `LOCK_MAX` consecutive. Then one mandatory IDLE cycle, where a pending CPU request wins because `last = 1`.
- Slave wait states extend GRANTn indefinitely. There is no timeout.
- Outputs in GRANT states are combinational from the granted master and slave. `grant` is registered (decoded from state).

## Test plan
- Reset: hold `reset = 0` 2 cycles with both masters requesting -> `grant = 00`, `s_read = s_write = 0`, `m0_waitrequest = m1_waitrequest = 1`. Release -> `grant = 01` one cycle later.
- Single CPU write: m0 writes 0x00000069 to 0x32, byteenable 0001, zero-wait RAM -> `grant = 01` for one cycle, `s_write = 1`, `s_address = 0x32`, `m0_waitrequest = 0` that cycle. RAM word 0x32 holds 0x69 afterwards.
- Round-robin: both masters issue continuous reads of 0x04 / 0x08 -> grants alternate 01, 00, 10, 00, 01, ... Each master gets `s_readdata` only in its own grant cycle; the other sees readdata 0.
- Lock: m1 writes 20 words at 0x00..0x4C with `m1_lock = 1` while m0 requests a read of 0x04 throughout (`LOCK_MAX = 16`) -> `grant = 10` for 16 consecutive cycles, then IDLE, then `grant = 01` for the CPU read, then m1 resumes.
- Wait states: RAM holds `s_waitrequest = 1` for 3 cycles on an m0 read, with m1 requesting -> `grant` stays 01 for 4 cycles and `m1_waitrequest = 1` throughout. m1 is granted after the following IDLE cycle.
- Reset mid-transfer: assert `reset = 0` during the second wait cycle of an m1 write -> next cycle `s_write = 0`, `grant = 00`, `lock_cnt = 0`. After release, m0 wins the tie.

Source files
------------

// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM bus bundle shared by the arbiter's master-side and slave-side ports.
// The master modport is the side issuing requests; the slave modport answers them.
interface avalon_mem_arbiter_if;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    output byteenable,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    input  byteenable,
    output waitrequest,
    output readdata
  );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Round-robin two-master Avalon-MM arbiter in front of a single RAM slave, with a
// bounded bus lock for the loader master (master 1).
module avalon_mem_arbiter #(
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  avalon_mem_arbiter_if.slave         m0,
  avalon_mem_arbiter_if.slave         m1,
  input  logic                        m1_lock,
  avalon_mem_arbiter_if.master        s,
  output logic [1:0]                  grant
);

  typedef enum logic [1:0] {StIdle, StGrant0, StGrant1} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;

  logic req0, req1;
  logic lock_room;

  assign req0 = m0.read | m0.write;
  assign req1 = m1.read | m1.write;
  // Another locked transfer is allowed only while the run stays below LOCK_MAX.
  assign lock_room = (32'(lock_cnt_q) + 32'd1) < LOCK_MAX;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StIdle;
      last_q     <= 1'b1;
      lock_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      StIdle: begin
        if (req0 && req1) begin
          state_d = last_q ? StGrant0 : StGrant1;
        end else if (req0) begin
          state_d = StGrant0;
        end else if (req1) begin
          state_d = StGrant1;
        end
      end
      StGrant0: begin
        if (!req0) begin
          state_d = StIdle;
        end else if (!s.waitrequest) begin
          state_d = StIdle;
          last_d  = 1'b0;
        end
      end
      StGrant1: begin
        if (!req1) begin
          state_d    = StIdle;
          lock_cnt_d = 8'd0;
        end else if (!s.waitrequest) begin
          last_d = 1'b1;
          if (m1_lock && lock_room) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
          end else begin
            state_d    = StIdle;
            lock_cnt_d = 8'd0;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Data path: slave follows the owner; the non-owner is stalled with zero readdata.
  always_comb begin
    s.address      = 32'd0;
    s.read         = 1'b0;
    s.write        = 1'b0;
    s.writedata    = 32'd0;
    s.byteenable   = 4'd0;
    m0.waitrequest = 1'b1;
    m0.readdata    = 32'd0;
    m1.waitrequest = 1'b1;
    m1.readdata    = 32'd0;
    case (state_q)
      StGrant0: begin
        s.address      = m0.address;
        s.read         = m0.read;
        s.write        = m0.write;
        s.writedata    = m0.writedata;
        s.byteenable   = m0.byteenable;
        m0.waitrequest = s.waitrequest;
        m0.readdata    = s.readdata;
      end
      StGrant1: begin
        s.address      = m1.address;
        s.read         = m1.read;
        s.write        = m1.write;
        s.writedata    = m1.writedata;
        s.byteenable   = m1.byteenable;
        m1.waitrequest = s.waitrequest;
        m1.readdata    = s.readdata;
      end
      default: ;
    endcase
  end

  assign grant = {state_q == StGrant1, state_q == StGrant0};

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Directed bench for avalon_mem_arbiter with a small byte-enabled RAM model.
module tb_avalon_mem_arbiter;
  logic       clk;
  logic       rst;
  logic       m1_lock;
  logic       ram_wait;
  logic [1:0] grant;
  int         checks;
  int         errors;

  avalon_mem_arbiter_if m0_bus ();
  avalon_mem_arbiter_if m1_bus ();
  avalon_mem_arbiter_if s_bus ();

  avalon_mem_arbiter #(.LOCK_MAX(16)) dut (
    .clk     (clk),
    .reset   (rst),
    .m0      (m0_bus),
    .m1      (m1_bus),
    .m1_lock (m1_lock),
    .s       (s_bus),
    .grant   (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM: word per address byte, preset to a known pattern while reset is low.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 | i;
    end else if (s_bus.write && !s_bus.waitrequest) begin
      for (int b = 0; b < 4; b++)
        if (s_bus.byteenable[b]) mem[s_bus.address[7:0]][8*b +: 8] <= s_bus.writedata[8*b +: 8];
    end
  end
  assign s_bus.waitrequest = ram_wait;
  assign s_bus.readdata    = s_bus.read ? mem[s_bus.address[7:0]] : 32'h0;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    m0_bus.read = 1'b0; m0_bus.write = 1'b0; m0_bus.address = 32'h0;
    m0_bus.writedata = 32'h0; m0_bus.byteenable = 4'h0;
    m1_bus.read = 1'b0; m1_bus.write = 1'b0; m1_bus.address = 32'h0;
    m1_bus.writedata = 32'h0; m1_bus.byteenable = 4'h0;
    m1_lock = 1'b0;
  endtask

  task automatic apply_reset();
    idle_masters();
    ram_wait = 1'b0;
    rst = 1'b0;
    cycle();
    cycle();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_masters();
    ram_wait = 1'b0;
    m0_bus.read = 1'b1; m0_bus.address = 32'h04;
    m1_bus.read = 1'b1; m1_bus.address = 32'h08;
    rst = 1'b0;
    cycle();
    cycle();
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant: got %b expected 00", grant); end
    checks++; if (s_bus.read !== 1'b0 || s_bus.write !== 1'b0) begin
      errors++; $display("FAIL reset_strobes: got r=%b w=%b expected 0 0", s_bus.read, s_bus.write); end
    checks++; if (m0_bus.waitrequest !== 1'b1 || m1_bus.waitrequest !== 1'b1) begin
      errors++; $display("FAIL reset_wait: got %b %b expected 1 1", m0_bus.waitrequest, m1_bus.waitrequest); end
    checks++; if (s_bus.address !== 32'h0 || m0_bus.readdata !== 32'h0 || m1_bus.readdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got addr=%h rd0=%h rd1=%h expected 0", s_bus.address,
                         m0_bus.readdata, m1_bus.readdata); end
    rst = 1'b1;
    cycle();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL reset_release_grant: got %b expected 01", grant); end
    idle_masters();
  endtask

  task automatic test_single_write();
    apply_reset();
    m0_bus.write = 1'b1; m0_bus.address = 32'h32; m0_bus.writedata = 32'h69; m0_bus.byteenable = 4'b0001;
    cycle();
    checks++; if (grant !== 2'b01) begin errors++; $display("FAIL wr_grant: got %b expected 01", grant); end
    checks++; if (s_bus.write !== 1'b1 || s_bus.address !== 32'h32) begin
      errors++; $display("FAIL wr_bus: got w=%b addr=%h expected 1 00000032", s_bus.write, s_bus.address); end
    checks++; if (s_bus.writedata !== 32'h69 || s_bus.byteenable !== 4'b0001) begin
      errors++; $display("FAIL wr_data: got %h be=%b expected 00000069 0001", s_bus.writedata, s_bus.byteenable); end
    checks++; if (m0_bus.waitrequest !== 1'b0 || m1_bus.waitrequest !== 1'b1) begin
      errors++; $display("FAIL wr_wait: got %b %b expected 0 1", m0_bus.waitrequest, m1_bus.waitrequest); end
    cycle();
    idle_masters();
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL wr_after_grant: got %b expected 00", grant); end
    checks++; if (mem[8'h32] !== 32'hA5A5_0069) begin
      errors++; $display("FAIL wr_ram: got %h expected a5a50069", mem[8'h32]); end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_g [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    logic [31:0] exp_r0, exp_r1;
    apply_reset();
    m0_bus.read = 1'b1; m0_bus.address = 32'h04; m0_bus.byteenable = 4'hF;
    m1_bus.read = 1'b1; m1_bus.address = 32'h08; m1_bus.byteenable = 4'hF;
    for (int k = 0; k < 8; k++) begin
      cycle();
      exp_r0 = (exp_g[k] == 2'b01) ? 32'hA5A5_0004 : 32'h0;
      exp_r1 = (exp_g[k] == 2'b10) ? 32'hA5A5_0008 : 32'h0;
      checks++; if (grant !== exp_g[k]) begin
        errors++; $display("FAIL rr_grant cyc%0d: got %b expected %b", k, grant, exp_g[k]); end
      checks++; if (m0_bus.readdata !== exp_r0) begin
        errors++; $display("FAIL rr_rd0 cyc%0d: got %h expected %h", k, m0_bus.readdata, exp_r0); end
      checks++; if (m1_bus.readdata !== exp_r1) begin
        errors++; $display("FAIL rr_rd1 cyc%0d: got %h expected %h", k, m1_bus.readdata, exp_r1); end
    end
    idle_masters();
  endtask

  task automatic test_lock();
    int         idx;
    logic [1:0] exp, prev;
    apply_reset();
    m0_bus.read = 1'b1; m0_bus.address = 32'h04; m0_bus.byteenable = 4'hF;
    idx = 0;
    prev = 2'b00;
    m1_bus.write = 1'b1; m1_bus.address = 32'h0; m1_bus.writedata = 32'hC0DE_0000;
    m1_bus.byteenable = 4'hF; m1_lock = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      cycle();
      if (prev == 2'b10) idx++;
      m1_bus.write     = (idx < 20);
      m1_lock          = (idx < 19);
      m1_bus.address   = 32'(idx * 4);
      m1_bus.writedata = 32'hC0DE_0000 + 32'(idx);
      #1;
      if (k == 1 || k == 20 || k == 27)            exp = 2'b01;
      else if ((k >= 3 && k <= 18) || (k >= 22 && k <= 25)) exp = 2'b10;
      else                                         exp = 2'b00;
      checks++; if (grant !== exp) begin
        errors++; $display("FAIL lock_grant cyc%0d: got %b expected %b", k, grant, exp); end
      if (exp == 2'b10) begin
        checks++; if (m0_bus.waitrequest !== 1'b1 || s_bus.writedata !== 32'hC0DE_0000 + 32'(idx)) begin
          errors++; $display("FAIL lock_bus cyc%0d: got wait0=%b wd=%h expected 1 %h", k,
                             m0_bus.waitrequest, s_bus.writedata, 32'hC0DE_0000 + 32'(idx)); end
      end
      prev = exp;
    end
    checks++; if (mem[8'h00] !== 32'hC0DE_0000 || mem[8'h4C] !== 32'hC0DE_0013) begin
      errors++; $display("FAIL lock_ram: got %h %h expected c0de0000 c0de0013", mem[8'h00], mem[8'h4C]); end
    idle_masters();
  endtask

  task automatic test_wait_states();
    logic [1:0] exp_g [7] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b00};
    logic       exp_w0 [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic       exp_w1 [7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    apply_reset();
    m0_bus.read = 1'b1; m0_bus.address = 32'h10; m0_bus.byteenable = 4'hF;
    m1_bus.read = 1'b1; m1_bus.address = 32'h14; m1_bus.byteenable = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      ram_wait    = (k <= 3);
      m0_bus.read = (k <= 4);
      m1_bus.read = (k <= 6);
      #1;
      checks++; if (grant !== exp_g[k-1] || m0_bus.waitrequest !== exp_w0[k-1]
                    || m1_bus.waitrequest !== exp_w1[k-1]) begin
        errors++; $display("FAIL wait_cyc%0d: got g=%b w0=%b w1=%b expected %b %b %b", k, grant,
                           m0_bus.waitrequest, m1_bus.waitrequest, exp_g[k-1], exp_w0[k-1], exp_w1[k-1]);
      end
      if (k == 6) begin
        checks++; if (m1_bus.readdata !== 32'hA5A5_0014) begin
          errors++; $display("FAIL wait_rd1: got %h expected a5a50014", m1_bus.readdata); end
      end
    end
    idle_masters();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    m1_bus.write = 1'b1; m1_bus.address = 32'h1C; m1_bus.writedata = 32'h1111_1111;
    m1_bus.byteenable = 4'hF; m1_lock = 1'b1;
    cycle();
    checks++; if (grant !== 2'b10 || s_bus.write !== 1'b1) begin
      errors++; $display("FAIL mid_grant1: got g=%b w=%b expected 10 1", grant, s_bus.write); end
    cycle();
    m1_bus.address = 32'h20; m1_bus.writedata = 32'hDEAD_BEEF; ram_wait = 1'b1;
    #1;
    checks++; if (grant !== 2'b10 || dut.lock_cnt_q !== 8'd1 || m1_bus.waitrequest !== 1'b1) begin
      errors++; $display("FAIL mid_locked: got g=%b cnt=%0d w1=%b expected 10 1 1", grant,
                         dut.lock_cnt_q, m1_bus.waitrequest); end
    cycle();
    rst = 1'b0;
    cycle();
    checks++; if (s_bus.write !== 1'b0 || grant !== 2'b00 || dut.lock_cnt_q !== 8'd0) begin
      errors++; $display("FAIL mid_abort: got w=%b g=%b cnt=%0d expected 0 00 0", s_bus.write, grant,
                         dut.lock_cnt_q); end
    checks++; if (m1_bus.waitrequest !== 1'b1 || mem[8'h20] !== 32'hA5A5_0020) begin
      errors++; $display("FAIL mid_nowrite: got w1=%b ram=%h expected 1 a5a50020", m1_bus.waitrequest,
                         mem[8'h20]); end
    rst = 1'b1; ram_wait = 1'b0;
    m0_bus.read = 1'b1; m0_bus.address = 32'h24; m0_bus.byteenable = 4'hF;
    cycle();
    checks++; if (grant !== 2'b01 || s_bus.read !== 1'b1 || s_bus.address !== 32'h24) begin
      errors++; $display("FAIL mid_tie: got g=%b r=%b addr=%h expected 01 1 00000024", grant,
                         s_bus.read, s_bus.address); end
    idle_masters();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    ram_wait = 1'b0;
    idle_masters();
    test_reset();
    test_single_write();
    test_round_robin();
    test_lock();
    test_wait_states();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
